// File: rtl/count_pulse_gen_if.sv
// count_pulse_gen_if
// Signal bundle between the push-button conditioner and its environment.
//   btn_in    : raw, asynchronous, possibly bouncing button level
//   count     : one-cycle registered pulse, drives the counter's count input
//   pressed   : debounced button level
//   repeating : high while the auto-repeat FSM is in its REPEAT state
//   state_dbg : current FSM state encoding, for observation only
// Transfer semantics: there is no valid/ready pair. `count` is a pure
// strobe: each clock cycle in which it is high is exactly one counting
// event, and the consumer cannot apply back-pressure.
// Modports: master = button/counter side, slave = conditioner.
interface count_pulse_gen_if;
  logic       btn_in;
  logic       count;
  logic       pressed;
  logic       repeating;
  logic [1:0] state_dbg;

  modport master (
    output btn_in,
    input  count,
    input  pressed,
    input  repeating,
    input  state_dbg
  );

  modport slave (
    input  btn_in,
    output count,
    output pressed,
    output repeating,
    output state_dbg
  );
endinterface

// File: rtl/count_pulse_gen.sv
// count_pulse_gen
// Conditions a raw push-button into the enable pulse of a 4-bit up-counter:
// two-flop synchroniser, run-length debouncer, and a press/hold/repeat FSM
// that emits one pulse per press plus optional auto-repeat pulses.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : count_pulse_gen_if.slave (btn_in in; count, pressed,
//           repeating, state_dbg out)
module count_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 10,
  parameter int REPEAT_CYCLES   = 3,
  parameter int REPEAT_EN       = 1
) (
  input  logic               clock,
  input  logic               reset,
  count_pulse_gen_if.slave   bus
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  HOLD_SAT  = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0]  REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Synchroniser and debounce state
  logic           s1_q, s1_d;
  logic           btn_s_q, btn_s_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           pressed_q, pressed_d;

  // FSM state, timer and registered pulse
  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           count_q, count_d;

  logic press_rise;
  logic press_fall;
  logic hold_done;
  logic rep_done;
  logic repeat_on;

  assign repeat_on = (REPEAT_EN != 0);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= 1'b0;
      btn_s_q   <= 1'b0;
      db_cnt_q  <= '0;
      pressed_q <= 1'b0;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      count_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      btn_s_q   <= btn_s_d;
      db_cnt_q  <= db_cnt_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------------
  always_comb begin
    s1_d      = bus.btn_in;
    btn_s_d   = s1_q;
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    if (btn_s_q == pressed_q) begin
      // Any agreeing sample restarts the stability run.
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      // This edge is the DEBOUNCE_CYCLES-th consecutive disagreement.
      pressed_d = ~pressed_q;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Edge events are taken from the next debounced value so the press pulse
  // is registered on the same edge that `pressed` rises.
  assign press_rise = pressed_d & ~pressed_q;
  assign press_fall = ~pressed_d & pressed_q;
  assign hold_done  = (timer_q == HOLD_LAST);
  assign rep_done   = (timer_q == REP_LAST);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (press_rise) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (press_fall)                   state_d = ST_IDLE;
        else if (repeat_on && hold_done)  state_d = ST_REPEAT;
      end
      ST_REPEAT: begin
        if (press_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / timer logic. Release is checked first so an expiring timer
  // on the release edge produces no pulse.
  // ---------------------------------------------------------------------
  always_comb begin
    count_d = 1'b0;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (press_rise) count_d = 1'b1;
      end
      ST_HOLD: begin
        if (press_fall) begin
          timer_d = '0;
        end else if (repeat_on && hold_done) begin
          count_d = 1'b1;
          timer_d = '0;
        end else if (timer_q != HOLD_SAT) begin
          // Without auto-repeat the timer parks at HOLD_CYCLES.
          timer_d = timer_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (press_fall) begin
          timer_d = '0;
        end else if (rep_done) begin
          count_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
      end
    endcase
  end

  assign bus.count     = count_q;
  assign bus.pressed   = pressed_q;
  assign bus.repeating = (state_q == ST_REPEAT);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_count_pulse_gen.sv
// tb_count_pulse_gen
// Drives one button waveform into two conditioners (auto-repeat on and off)
// and compares count/pressed/repeating every cycle against a reference
// model derived from the debounce and pulse-timing rules.
module tb_count_pulse_gen;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic btn   = 1'b0;
  always #5 clock = ~clock;

  count_pulse_gen_if bus_r ();
  count_pulse_gen_if bus_n ();
  assign bus_r.btn_in = btn;
  assign bus_n.btn_in = btn;

  count_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
  ) dut_r (
    .clock(clock), .reset(reset), .bus(bus_r)
  );

  count_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(0)
  ) dut_n (
    .clock(clock), .reset(reset), .bus(bus_n)
  );

  // ---------------- scoreboard state ----------------
  // Packed expectation per edge: {count_r, repeating_r, count_n, repeating_n, pressed}
  logic [4:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int mark     = 0;   // 1: snapshot pulse totals, 2: compare totals since snapshot
  int cyc      = 0;
  int cnt_mod  = 0;
  int cnt_dut  = 0;

  // ---------------- reference model ----------------
  logic sync_q[$];    // button samples in flight through the two-flop sync
  logic hist[$];      // synchronised samples since the last debounced change
  bit   m_pressed;
  int   press_t;

  always @(posedge clock) begin
    bit bs, rise, fall, all_diff, c_r, r_r, c_n;
    int el;
    cyc = cyc + 1;
    if (reset) begin
      sync_q.delete();
      sync_q.push_back(1'b0);
      sync_q.push_back(1'b0);
      hist.delete();
      m_pressed = 1'b0;
      exp_q.push_back(5'b0);
    end else begin
      bs = sync_q.pop_front();
      sync_q.push_back(btn);
      hist.push_back(bs);
      if (hist.size() > DEB) void'(hist.pop_front());
      rise = 1'b0;
      fall = 1'b0;
      if (hist.size() == DEB) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i] == m_pressed) all_diff = 1'b0;
        if (all_diff) begin
          m_pressed = !m_pressed;
          rise = m_pressed;
          fall = !m_pressed;
          hist.delete();
          if (rise) press_t = cyc;
        end
      end
      c_r = 1'b0; r_r = 1'b0; c_n = 1'b0;
      if (rise) begin
        c_r = 1'b1;
        c_n = 1'b1;
      end else if (m_pressed) begin
        // Pulses while held: HOLD after the press, then every REP cycles.
        el = cyc - press_t;
        if (el >= HOLD) begin
          r_r = 1'b1;
          if (((el - HOLD) % REP) == 0) c_r = 1'b1;
        end
      end
      if (c_r) cnt_mod = cnt_mod + 1;
      exp_q.push_back({c_r, r_r, c_n, 1'b0, m_pressed});
    end
  end

  // ---------------- monitor ----------------
  task automatic check(input string name, input int act, input int exp);
    chk_cnt = chk_cnt + 1;
    if (act == exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  int base_d, base_m;
  always @(negedge clock) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count_rep",     int'(bus_r.count),     int'(e[4]));
      check("repeating_rep", int'(bus_r.repeating), int'(e[3]));
      check("count_norep",   int'(bus_n.count),     int'(e[2]));
      check("repeating_norep", int'(bus_n.repeating), int'(e[1]));
      check("pressed_rep",   int'(bus_r.pressed),   int'(e[0]));
      check("pressed_norep", int'(bus_n.pressed),   int'(e[0]));
      if (bus_r.count) cnt_dut = cnt_dut + 1;
    end
    if (mark == 1) begin
      base_d = cnt_dut;
      base_m = cnt_mod;
    end else if (mark == 2) begin
      check("counter_value", (cnt_dut - base_d) & 15, (cnt_mod - base_m) & 15);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit b, input int n);
    repeat (n) begin
      btn = b;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // Reset with a toggling button: everything must stay at zero.
    reset = 1'b1;
    repeat (3) begin
      btn = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    step(0, 10);

    // Clean press of 8 cycles.
    step(1, 8);
    step(0, 12);

    // Bounce: runs all shorter than the debounce length.
    step(1, 3); step(0, 1); step(1, 2); step(0, 1); step(1, 1);
    step(0, 10);
    // A stable run of exactly the debounce length.
    step(1, 4);
    step(0, 12);

    // Long hold. Releasing after 28 cycles lines the release up with a
    // repeat-timer expiry, which must not pulse; the counter then reads 7.
    mark = 1; step(1, 1); mark = 0;
    step(1, 27);
    step(0, 15);
    mark = 2; step(0, 1); mark = 0;

    // Reset during REPEAT with the button still held.
    step(1, 17);
    reset = 1'b1;
    step(1, 2);
    reset = 1'b0;
    step(1, 14);
    step(0, 12);

    // Held bounce while in HOLD/REPEAT must not disturb timing.
    step(1, 20); step(0, 2); step(1, 12); step(0, 1); step(1, 6);
    step(0, 12);

    // Random segments with occasional reset pulses.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1;
        step(1'($urandom_range(0, 1)), $urandom_range(1, 2));
        reset = 1'b0;
      end
      step(1'($urandom_range(0, 1)), $urandom_range(1, 24));
    end
    step(0, 15);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
